instruction_fetch: RTL

Fetch stage of the Forth core, directly downstream of the program counter. Each fetch samples the PC address, reads one instruction word from synchronous program memory and presents it to decode through a valid/ready handshake. It tells the PC to advance once per fetched word. Unconditional jumps are folded here: fetch drives the PC's `branch`/`offset` inputs and the jump never reaches decode.

---
 rtl/forth_pkg.sv | 18 +
 rtl/fetch_skid_reg.sv | 74 +++++++
 rtl/instruction_fetch.sv | 111 +++++++++++
 3 files changed

// File: rtl/forth_pkg.sv
// Shared Forth-core definitions: opcode fields used by fetch and the fetch FSM encoding.
package forth_pkg;
  localparam logic [4:0] JMP_OPCODE   = 5'b11100;
  localparam int         OPC_HI       = 15;
  localparam int         OPC_LO       = 11;
  localparam int         OFFSET_WIDTH = 11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    STALL
  } fetch_state_t;

  function automatic logic is_jmp(input logic [OPC_HI-OPC_LO:0] opc);
    return opc == JMP_OPCODE;
  endfunction
endpackage

// File: rtl/fetch_skid_reg.sv
// Output register plus one-deep pending register toward decode (valid/ready).
module fetch_skid_reg #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  input  logic [AW-1:0] in_pc_i,
  output logic          accept_o,
  output logic [DW-1:0] out_data_o,
  output logic [AW-1:0] out_pc_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);
  logic [DW-1:0] out_data_q, out_data_d, pend_data_q, pend_data_d;
  logic [AW-1:0] out_pc_q, out_pc_d, pend_pc_q, pend_pc_d;
  logic          out_valid_q, out_valid_d, pend_valid_q, pend_valid_d;
  logic          xfer;

  assign xfer     = out_valid_q & out_ready_i;
  assign accept_o = ~out_valid_q | out_ready_i;

  always_comb begin
    out_data_d   = out_data_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = out_valid_q;
    pend_data_d  = pend_data_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    if (xfer) out_valid_d = 1'b0;
    // A consumed output is refilled from the pending slot in the same cycle.
    if (xfer && pend_valid_q) begin
      out_data_d   = pend_data_q;
      out_pc_d     = pend_pc_q;
      out_valid_d  = 1'b1;
      pend_valid_d = 1'b0;
    end
    if (in_valid_i) begin
      if (accept_o) begin
        out_data_d  = in_data_i;
        out_pc_d    = in_pc_i;
        out_valid_d = 1'b1;
      end else begin
        pend_data_d  = in_data_i;
        pend_pc_d    = in_pc_i;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q   <= '0;
      out_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      pend_data_q  <= '0;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_pc_q     <= out_pc_d;
      out_valid_q  <= out_valid_d;
      pend_data_q  <= pend_data_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_pc_o    = out_pc_q;
  assign out_valid_o = out_valid_q;
endmodule

// File: rtl/instruction_fetch.sv
// Forth-core fetch stage: reads program memory at the PC and hands words to decode.
// FETCH_JMP_FOLD_EN: fold unconditional JMPs into a PC branch instead of passing them on.
module instruction_fetch
  import forth_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   pc_addr,
  output logic                    pc_advance,
  output logic                    branch,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic                    mem_rd,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [INSTR_WIDTH-1:0]  mem_data,
  output logic [INSTR_WIDTH-1:0]  instr,
  output logic [ADDR_WIDTH-1:0]   instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready
);
  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  fold, sk_in_valid, sk_accept;

`ifdef FETCH_JMP_FOLD_EN
  assign fold = is_jmp(mem_data[OPC_HI:OPC_LO]);
`else
  assign fold = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_advance  = 1'b0;
    branch      = 1'b0;
    offset      = '0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    sk_in_valid = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        mem_rd     = 1'b1;
        mem_addr   = pc_addr;
        fetch_pc_d = pc_addr;
        state_d    = RESP;
      end
      RESP: begin
        if (fold) begin
          pc_advance = 1'b1;
          branch     = 1'b1;
          offset     = mem_data[OFFSET_WIDTH-1:0];
          state_d    = REQ;
        end else begin
          sk_in_valid = 1'b1;
          if (sk_accept) begin
            pc_advance = 1'b1;
            state_d    = REQ;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        // Output is necessarily full here, so ready means it drains this cycle.
        if (instr_ready) begin
          pc_advance = 1'b1;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over whatever state the FSM was in during this cycle.
    if (reset) begin
      pc_advance  = 1'b0;
      branch      = 1'b0;
      offset      = '0;
      mem_rd      = 1'b0;
      mem_addr    = '0;
      sk_in_valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_skid_reg #(
    .DW(INSTR_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_skid (
    .clock      (clock),
    .reset      (reset),
    .in_valid_i (sk_in_valid),
    .in_data_i  (mem_data),
    .in_pc_i    (fetch_pc_q),
    .accept_o   (sk_accept),
    .out_data_o (instr),
    .out_pc_o   (instr_pc),
    .out_valid_o(instr_valid),
    .out_ready_i(instr_ready)
  );
endmodule
